vad_decision_smoother: RTL and testbench

//  Consumer of the 2-bit per-frame class code from the classifier compare stage.

---
 rtl/vad_decision_smoother_if.sv | 16 +
 rtl/vad_decision_smoother.sv | 147 ++++++++++++++
 tb/tb_vad_decision_smoother.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vad_decision_smoother_if.sv
// Bus between the classifier compare stage, the smoother and the host reader.
// Handshake: result_valid is a one-cycle strobe with no back-pressure; a record moves
// from out_data to the host on every rising clk where out_valid and out_ready are both 1.
// While out_valid is 1 and out_ready is 0, out_data stays stable.
interface vad_decision_smoother_if #(
  parameter int FIDX_W = 8
) ();
  logic [1:0]      result_in;
  logic            result_valid;
  logic            out_valid;
  logic            out_ready;
  logic [FIDX_W:0] out_data;

  modport master (output result_in, result_valid, out_ready, input out_valid, out_data);
  modport slave  (input result_in, result_valid, out_ready, output out_valid, out_data);
endinterface

// File: rtl/vad_decision_smoother.sv
// Turns per-frame class codes into a smoothed speech/non-speech decision (onset + hangover)
// and queues {vad_flag, frame_idx} records in a show-ahead FIFO for the host.
module vad_decision_smoother #(
  parameter int ONSET_FRAMES = 3,
  parameter int HANG_FRAMES  = 2,
  parameter int FIDX_W       = 8,
  parameter int DEPTH        = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  vad_decision_smoother_if.slave bus,
  output logic                   vad_flag,
  output logic                   overflow,
  output logic                   code_err,
  output logic [1:0]             fsm_state
);
  localparam int CW = (ONSET_FRAMES < 2) ? 1 : $clog2(ONSET_FRAMES + 1);
  localparam int HW = (HANG_FRAMES < 2) ? 1 : $clog2(HANG_FRAMES + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int RW = FIDX_W + 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {SILENCE = 2'd0, ONSET = 2'd1, SPEECH = 2'd2, HANGOVER = 2'd3} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [HW-1:0]     hcnt, hcnt_n;
  logic              vad_n;
  logic              is_s, is_n, frame_evt;
  logic [FIDX_W-1:0] frame_idx;

  logic [RW-1:0]     mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, pop, push_ok;

  // Codes 00 and 11 are not frames: they neither step the FSM nor consume an index.
  assign is_s      = (bus.result_in == 2'b10);
  assign is_n      = (bus.result_in == 2'b01);
  assign frame_evt = bus.result_valid & (is_s | is_n);
  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SILENCE;
      cnt      <= '0;
      hcnt     <= '0;
      vad_flag <= 1'b0;
    end else if (clear) begin
      state    <= SILENCE;
      cnt      <= '0;
      hcnt     <= '0;
      vad_flag <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      hcnt     <= hcnt_n;
      vad_flag <= vad_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hcnt_n  = hcnt;
    if (frame_evt) begin
      case (state)
        SILENCE: if (is_s) begin
          cnt_n   = CW'(1);
          state_n = (ONSET_FRAMES == 1) ? SPEECH : ONSET;
        end
        ONSET: if (is_s) begin
          cnt_n = cnt + 1'b1;
          if (cnt + 1'b1 == CW'(ONSET_FRAMES)) state_n = SPEECH;
        end else begin
          cnt_n   = '0;
          state_n = SILENCE;
        end
        SPEECH: if (is_n) begin
          hcnt_n  = HW'(HANG_FRAMES);
          state_n = (HANG_FRAMES == 0) ? SILENCE : HANGOVER;
        end
        HANGOVER: if (is_s) begin
          state_n = SPEECH;
        end else if (hcnt == HW'(1)) begin
          state_n = SILENCE;
        end else begin
          hcnt_n = hcnt - 1'b1;
        end
        default: state_n = SILENCE;
      endcase
    end
  end

  always_comb begin
    vad_n = (state_n == SPEECH) || (state_n == HANGOVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_idx <= '0;
      code_err  <= 1'b0;
    end else if (clear) begin
      frame_idx <= '0;
      code_err  <= 1'b0;
    end else begin
      if (frame_evt) frame_idx <= frame_idx + 1'b1;
      if (bus.result_valid && bus.result_in == 2'b11) code_err <= 1'b1;
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign full    = (count == FULL_CNT);
  assign pop     = bus.out_valid & bus.out_ready;
  assign push_ok = frame_evt & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (frame_evt && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {vad_n, frame_idx};
  end

  assign bus.out_valid = (count != '0);
  assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;
endmodule

// File: tb/tb_vad_decision_smoother.sv
// Bench for vad_decision_smoother: directed vector tables and corner sequences, plus
// random traffic checked every cycle against a run-length decision model and a FIFO queue.
module tb_vad_decision_smoother;
  localparam int ONSET  = 3;
  localparam int HANG   = 2;
  localparam int FIDX_W = 8;
  localparam int DEPTH  = 4;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       vad_flag, overflow, code_err;
  logic [1:0] fsm_state;

  vad_decision_smoother_if #(.FIDX_W(FIDX_W)) vif ();

  vad_decision_smoother #(
    .ONSET_FRAMES(ONSET), .HANG_FRAMES(HANG), .FIDX_W(FIDX_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .bus(vif),
    .vad_flag(vad_flag), .overflow(overflow), .code_err(code_err), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: decision from speech / non-speech run lengths
  logic              m_active;
  int                s_run, n_run;
  logic [FIDX_W-1:0] m_idx;
  logic              m_ovf, m_cerr;
  logic [FIDX_W:0]   exp_q[$];
  logic [FIDX_W:0]   got_q[$];

  task automatic model_reset();
    m_active = 1'b0; s_run = 0; n_run = 0; m_idx = '0;
    m_ovf = 1'b0; m_cerr = 1'b0; exp_q.delete();
  endtask

  task automatic model_step(input logic s);
    if (!m_active) begin
      if (s) begin
        s_run++;
        if (s_run >= ONSET) begin m_active = 1'b1; n_run = 0; end
      end else s_run = 0;
    end else begin
      if (s) n_run = 0;
      else begin
        n_run++;
        if (n_run > HANG) begin m_active = 1'b0; s_run = 0; end
      end
    end
  endtask

  // scoreboard: compare the state before the coming edge, then advance the model over it
  always @(negedge clk) begin
    if (!rst_n) model_reset();
    else begin
      logic            pop, evt;
      logic [FIDX_W:0] head;
      head = (exp_q.size() > 0) ? exp_q[0] : '0;
      check("sb_out_valid", 32'(vif.out_valid), 32'(exp_q.size() > 0));
      check("sb_out_data",  32'(vif.out_data),  32'(head));
      check("sb_vad_flag",  32'(vad_flag),      32'(m_active));
      check("sb_overflow",  32'(overflow),      32'(m_ovf));
      check("sb_code_err",  32'(code_err),      32'(m_cerr));
      if (clear) model_reset();
      else begin
        pop = (exp_q.size() > 0) && vif.out_ready;
        evt = vif.result_valid && (vif.result_in == 2'b10 || vif.result_in == 2'b01);
        if (vif.result_valid && vif.result_in == 2'b11) m_cerr = 1'b1;
        if (evt) model_step(vif.result_in == 2'b10);
        if (pop) void'(exp_q.pop_front());
        if (evt) begin
          if (exp_q.size() < DEPTH) exp_q.push_back({m_active, m_idx});
          else m_ovf = 1'b1;
          m_idx = m_idx + 1'b1;
        end
      end
    end
  end

  // host-side capture of every accepted record
  always @(negedge clk) begin
    if (rst_n && !clear && vif.out_valid && vif.out_ready) got_q.push_back(vif.out_data);
  end

  // driver tasks
  task automatic send(input logic [1:0] code);
    @(posedge clk); #1;
    vif.result_in = code; vif.result_valid = 1'b1;
    @(posedge clk); #1;
    vif.result_valid = 1'b0; vif.result_in = 2'b00;
  endtask

  task automatic pulse_clear();
    @(posedge clk); #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int k = 0;
    while (got_q.size() < n && k < 100) begin @(posedge clk); #1; k++; end
    check("got_count", 32'(got_q.size()), 32'(n));
  endtask

  typedef struct {
    logic [1:0] code;
    logic       exp_flag;
  } vec_t;

  localparam logic [1:0] S = 2'b10;
  localparam logic [1:0] N = 2'b01;

  initial begin
    vec_t vecs[17];
    vecs = '{'{S,0}, '{S,0}, '{N,0}, '{S,0}, '{S,0}, '{S,1},
             '{N,1}, '{N,1}, '{N,0}, '{S,0},
             '{S,0}, '{S,1},
             '{N,1}, '{S,1}, '{N,1}, '{N,1}, '{N,0}};

    rst_n = 1'b0; clear = 1'b0;
    vif.result_in = 2'b00; vif.result_valid = 1'b0; vif.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset state, then idle
    for (int r = 0; r < 2; r++) begin
      check("rst_out_valid", 32'(vif.out_valid), 0);
      check("rst_out_data",  32'(vif.out_data),  0);
      check("rst_vad_flag",  32'(vad_flag),      0);
      check("rst_overflow",  32'(overflow),      0);
      check("rst_code_err",  32'(code_err),      0);
      check("rst_fsm_state", 32'(fsm_state),     0);
      repeat (10) @(posedge clk);
      #1;
    end

    // onset and hangover vector table
    vif.out_ready = 1'b1;
    got_q.delete();
    for (int i = 0; i < 17; i++) begin
      send(vecs[i].code);
      check("tbl_vad_flag", 32'(vad_flag), 32'(vecs[i].exp_flag));
    end
    wait_got(17);
    for (int i = 0; i < 17 && i < got_q.size(); i++) begin
      logic [7:0] ix;
      ix = 8'(i);
      check("tbl_record", 32'(got_q[i]), 32'({vecs[i].exp_flag, ix}));
    end

    // overflow: 6 frames into a 4-deep FIFO with the host stalled
    pulse_clear();
    vif.out_ready = 1'b0;
    repeat (6) send(S);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_out_valid", 32'(vif.out_valid), 1);
    got_q.delete();
    vif.out_ready = 1'b1;
    wait_got(4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      logic [7:0] ix;
      logic       fl;
      ix = 8'(i);
      fl = (i >= 2);
      check("ovf_record", 32'(got_q[i]), 32'({fl, ix}));
    end
    got_q.delete();
    send(S);
    wait_got(1);
    if (got_q.size() > 0) check("ovf_next_idx", 32'(got_q[0]), 32'({1'b1, 8'd6}));
    check("ovf_sticky", 32'(overflow), 1);

    // codes 00 / 11 skip index and FSM
    pulse_clear();
    got_q.delete();
    send(S); send(2'b00);
    check("cerr_after_00", 32'(code_err), 0);
    send(2'b11);
    check("cerr_after_11", 32'(code_err), 1);
    send(S);
    check("skip_vad_2s", 32'(vad_flag), 0);
    send(2'b00); send(S);
    check("skip_vad_3s", 32'(vad_flag), 1);
    check("skip_state", 32'(fsm_state), 2);
    wait_got(3);
    if (got_q.size() >= 3) begin
      check("skip_rec0", 32'(got_q[0]), 32'({1'b0, 8'd0}));
      check("skip_rec1", 32'(got_q[1]), 32'({1'b0, 8'd1}));
      check("skip_rec2", 32'(got_q[2]), 32'({1'b1, 8'd2}));
    end

    // clear in HANGOVER wins over a simultaneous speech frame
    pulse_clear();
    vif.out_ready = 1'b0;
    send(S); send(S); send(S); send(N);
    check("hang_state", 32'(fsm_state), 3);
    check("hang_vad", 32'(vad_flag), 1);
    check("hang_out_valid", 32'(vif.out_valid), 1);
    @(posedge clk); #1;
    clear = 1'b1; vif.result_valid = 1'b1; vif.result_in = S;
    @(posedge clk); #1;
    clear = 1'b0; vif.result_valid = 1'b0; vif.result_in = 2'b00;
    check("clr_out_valid", 32'(vif.out_valid), 0);
    check("clr_out_data", 32'(vif.out_data), 0);
    check("clr_state", 32'(fsm_state), 0);
    check("clr_vad", 32'(vad_flag), 0);
    vif.out_ready = 1'b1;
    got_q.delete();
    send(S);
    wait_got(1);
    if (got_q.size() > 0) check("clr_idx0", 32'(got_q[0]), 32'({1'b0, 8'd0}));

    // random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      int r;
      @(posedge clk); #1;
      r = $urandom_range(0, 9);
      vif.result_in    = (r < 5) ? 2'b10 : (r < 8) ? 2'b01 : (r == 8) ? 2'b00 : 2'b11;
      vif.result_valid = ($urandom_range(0, 2) != 0);
      vif.out_ready    = ((c / 60) % 2 == 1) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      clear            = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1;
    vif.result_valid = 1'b0; vif.out_ready = 1'b1; clear = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
